stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Datapath stage directly downstream of the stopwatch control FSM. It consumes the FSM's RUN, CLEAR and LAP control outputs. It divides clk down to a 100 Hz tick and keeps a 4-digit BCD elapsed-time count in SS.cc form, running 00.00 to 59.99. It also provides a lap-freeze display register and returns ZERO and OVF status to the FSM.

Parameters:
- TICK_DIV, 1000000, clk cycles per hundredth-second tick (100 MHz -> 100 Hz); must be >= 2.
- PRE_W, 20, prescaler counter width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  input  1  system clock
- RESET  input  1  synchronous, active-high reset; clock clk
- RUN  input  1  level; 1 = count advances
- CLEAR  input  1  level; synchronous clear of count, prescaler, lap register, OVF
- LAP  input  1  level; 1 = freeze DISP_DIGITS while counting continues
- DISP_DIGITS  output  16  {sec_tens, sec_ones, tenths, hundredths}, 4 bits BCD each
- TICK  output  1  combinational; high in the cycle a hundredth increment is committed
- ZERO  output  1  combinational; 1 when live count == 00.00
- OVF  output  1  registered one-cycle pulse after a 59.99 -> 00.00 wrap

Behaviour:
- Registers: pre_cnt[PRE_W-1:0], live digits d3..d0, hold digits h3..h0, ovf_r.
- Priority at each posedge: RESET > CLEAR > count/lap update.
- RESET or CLEAR: pre_cnt, all live digits, all hold digits and ovf_r go to 0. This holds regardless of RUN and LAP. Mid-count reset loses the fractional prescaler state.
- Outputs in the cycle after RESET or CLEAR: DISP_DIGITS = 16'h0000, ZERO = 1, OVF = 0, TICK = 0.
- TICK = RUN & ~CLEAR & ~RESET & (pre_cnt == TICK_DIV-1).
- Prescaler:
  - If RUN = 1 and TICK = 0: pre_cnt increments.
  - If TICK = 1: pre_cnt wraps to 0.
  - If RUN = 0: pre_cnt holds, so pause/resume keeps partial-tick progress.
- Latency: from the first edge that samples RUN = 1 with pre_cnt = 0, the first increment commits on edge TICK_DIV.
- BCD cascade, applied on TICK edges only:
  - d0 (0-9) increments. On 9 it goes to 0 and carries to d1 (0-9).
  - d1 carries to d2 (0-9) the same way.
  - d2 on 9 with carry goes to 0 and carries to d3 (0-5).
  - d3 on 5 with carry goes to 0.
- Wrap 59.99 -> 00.00: ovf_r is set on that edge and cleared on the next edge, so OVF is high for exactly one cycle.
- Digits never take an illegal value: d0-d2 <= 9, d3 <= 5.
- Lap register:
  - On every edge where LAP = 0 (and no RESET/CLEAR), the hold digits load the post-edge live value.
  - When LAP = 1, the hold digits are unchanged.
- DISP_DIGITS = LAP ? {h3,h2,h1,h0} : {d3,d2,d1,d0}. Releasing LAP shows the live count immediately, in the same cycle.
- Simultaneous events:
  - CLEAR with RUN = 1: the clear wins, with no tick that cycle.
  - CLEAR with LAP = 1: the hold digits clear too, and DISP shows 0000.
  - LAP toggling on a TICK edge: the hold digits capture the pre-increment value if LAP was sampled 1, and the post-increment value if LAP was sampled 0.
- No internal FSM beyond counters. All control sequencing comes from upstream.

Test Plan (TICK_DIV = 4 in simulation):
- RESET for 2 cycles, then RUN = 1 held 40 cycles -> TICK high on run-cycles 4, 8, …, 40; DISP_DIGITS = 16'h0010; ZERO = 0.
- RUN = 1 for 6 cycles, RUN = 0 for 10, RUN = 1 again -> DISP holds 16'h0001 while paused; next TICK comes 2 cycles after resume; DISP = 16'h0002.
- Cascade checks -> 00.09 -> 00.10, 00.99 -> 01.00, 09.99 -> 10.00, each on a single TICK edge; no intermediate illegal digit seen.
- Preload via 5999 ticks to 59.99, then one more TICK -> DISP = 16'h0000, ZERO = 1, OVF = 1 for exactly one cycle, then OVF = 0 with counting continuing.
- At 00.05 assert LAP, run 20 ticks -> DISP stays 16'h0005 while live reaches 00.25 (check ZERO = 0); deassert LAP -> DISP = 16'h0025 in the same cycle.
- At 12.34 with RUN = 1 and LAP = 1, pulse CLEAR for one cycle -> next cycle DISP = 16'h0000, ZERO = 1, no TICK; with RUN still 1, the first TICK comes 4 cycles later. Repeat with RESET instead of CLEAR -> identical result.

Source files
------------

// File: rtl/stopwatch_time_counter.sv
// Stopwatch datapath: 100 Hz prescaler, SS.cc BCD elapsed-time counter,
// lap-freeze display register and ZERO/OVF status back to the control FSM.
module stopwatch_time_counter #(
   parameter int unsigned TICK_DIV = 1000000,
   parameter int unsigned PRE_W    = 20
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        RUN,
   input  logic        CLEAR,
   input  logic        LAP,
   output logic [15:0] DISP_DIGITS,
   output logic        TICK,
   output logic        ZERO,
   output logic        OVF
);

   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = 4 * DIG_W;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [DIG_W-1:0] d0_q, d1_q, d2_q, d3_q;
   logic [DIG_W-1:0] d0_d, d1_d, d2_d, d3_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] live_c;
   logic [CNT_W-1:0] live_d;

   assign live_c = {d3_q, d2_q, d1_q, d0_q};
   assign live_d = {d3_d, d2_d, d1_d, d0_d};

   // A tick needs the prescaler at terminal count and no clear/reset this cycle.
   assign TICK = RUN & ~CLEAR & ~RESET & (pre_q == PRE_W'(TICK_DIV - 1));

   always_comb begin
      pre_d = pre_q;
      if (TICK) begin
         pre_d = '0;
      end else if (RUN) begin
         pre_d = pre_q + PRE_W'(1);
      end
   end

   // BCD ripple: hundredths -> tenths -> seconds ones -> seconds tens (0-5).
   always_comb begin
      d0_d  = d0_q;
      d1_d  = d1_q;
      d2_d  = d2_q;
      d3_d  = d3_q;
      ovf_d = 1'b0;
      if (TICK) begin
         if (d0_q != DIG_W'(9)) begin
            d0_d = d0_q + DIG_W'(1);
         end else begin
            d0_d = '0;
            if (d1_q != DIG_W'(9)) begin
               d1_d = d1_q + DIG_W'(1);
            end else begin
               d1_d = '0;
               if (d2_q != DIG_W'(9)) begin
                  d2_d = d2_q + DIG_W'(1);
               end else begin
                  d2_d = '0;
                  if (d3_q != DIG_W'(5)) begin
                     d3_d = d3_q + DIG_W'(1);
                  end else begin
                     d3_d  = '0;
                     ovf_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Hold register tracks the post-edge live value unless the lap is frozen.
   always_comb begin
      hold_d = hold_q;
      if (!LAP) begin
         hold_d = live_d;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET || CLEAR) begin
         pre_q  <= '0;
         d0_q   <= '0;
         d1_q   <= '0;
         d2_q   <= '0;
         d3_q   <= '0;
         hold_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         d0_q   <= d0_d;
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         d3_q   <= d3_d;
         hold_q <= hold_d;
         ovf_q  <= ovf_d;
      end
   end

   // Display mux follows LAP directly so a release shows live time at once.
   assign DISP_DIGITS = LAP ? hold_q : live_c;
   assign ZERO        = (live_c == '0);
   assign OVF         = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboarded bench for stopwatch_time_counter: a hundredths-count reference
// model queues per-cycle expectations that a negedge monitor checks.
module tb_stopwatch_time_counter;

   localparam int TICK_DIV = 4;
   localparam int PRE_W    = 3;

   logic        clk = 1'b0;
   logic        RESET, RUN, CLEAR, LAP;
   logic [15:0] DISP_DIGITS;
   logic        TICK, ZERO, OVF;

   stopwatch_time_counter #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
      .clk(clk), .RESET(RESET), .RUN(RUN), .CLEAR(CLEAR), .LAP(LAP),
      .DISP_DIGITS(DISP_DIGITS), .TICK(TICK), .ZERO(ZERO), .OVF(OVF)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] disp;
      logic        tick;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   sb_en  = 1'b0;

   // Reference model: elapsed time as an integer number of hundredths.
   int m_pre, m_tot, m_hold;
   bit m_ovf;

   function automatic logic [15:0] bcd(input int t);
      return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb_en) begin
         if (q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_disp", 32'(DISP_DIGITS), 32'(e.disp));
            chk("sb_tick", 32'(TICK), 32'(e.tick));
            chk("sb_zero", 32'(ZERO), 32'(e.zero));
            chk("sb_ovf",  32'(OVF),  32'(e.ovf));
         end
      end
   end

   task automatic set_in(input bit r, input bit c, input bit l, input bit s);
      exp_t e;
      RUN = r; CLEAR = c; LAP = l; RESET = s;
      e.tick = r && !c && !s && (m_pre == TICK_DIV - 1);
      e.zero = (m_tot == 0);
      e.disp = l ? bcd(m_hold) : bcd(m_tot);
      e.ovf  = m_ovf;
      q.push_back(e);
      if (s || c) begin
         m_pre = 0; m_tot = 0; m_hold = 0; m_ovf = 0;
      end else begin
         if (e.tick) begin
            m_pre = 0;
            m_ovf = (m_tot == 5999);
            m_tot = (m_tot + 1) % 6000;
         end else begin
            m_ovf = 0;
            if (r) m_pre++;
         end
         if (!l) m_hold = m_tot;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit r, input bit c, input bit l, input bit s, input int n);
      for (int i = 0; i < n; i++) begin
         set_in(r, c, l, s);
         step();
      end
   endtask

   task automatic lap_clear_test(input bit use_rst);
      cyc(0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 1234 * TICK_DIV);
      chk("at_1234", 32'(DISP_DIGITS), 32'h1234);
      cyc(1, 0, 1, 0, TICK_DIV - 1);
      set_in(1, !use_rst, 1, use_rst);
      #1;
      chk("clr_no_tick", 32'(TICK), 32'd0);
      step();
      chk("clr_disp", 32'(DISP_DIGITS), 32'h0000);
      chk("clr_zero", 32'(ZERO), 32'd1);
      chk("clr_ovf", 32'(OVF), 32'd0);
      cyc(1, 0, 1, 0, TICK_DIV - 1);
      set_in(1, 0, 1, 0);
      #1;
      chk("first_tick_after_clr", 32'(TICK), 32'd1);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b1; RUN = 1'b0; CLEAR = 1'b0; LAP = 1'b0;
      step();
      step();
      m_pre = 0; m_tot = 0; m_hold = 0; m_ovf = 0;
      sb_en = 1'b1;

      // Basic run: ten ticks in forty run cycles.
      cyc(0, 0, 0, 1, 2);
      chk("rst_disp", 32'(DISP_DIGITS), 32'h0000);
      chk("rst_zero", 32'(ZERO), 32'd1);
      cyc(1, 0, 0, 0, TICK_DIV - 1);
      set_in(1, 0, 0, 0);
      #1;
      chk("first_tick", 32'(TICK), 32'd1);
      step();
      cyc(1, 0, 0, 0, 40 - TICK_DIV);
      chk("run40_disp", 32'(DISP_DIGITS), 32'h0010);
      chk("run40_zero", 32'(ZERO), 32'd0);

      // Pause keeps partial prescaler progress.
      cyc(0, 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 6);
      cyc(0, 0, 0, 0, 10);
      chk("pause_disp", 32'(DISP_DIGITS), 32'h0001);
      cyc(1, 0, 0, 0, 1);
      set_in(1, 0, 0, 0);
      #1;
      chk("resume_tick", 32'(TICK), 32'd1);
      step();
      chk("resume_disp", 32'(DISP_DIGITS), 32'h0002);

      // Cascade boundaries and the 59.99 wrap.
      cyc(0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 9 * TICK_DIV);
      chk("c0009", 32'(DISP_DIGITS), 32'h0009);
      cyc(1, 0, 0, 0, TICK_DIV);
      chk("c0010", 32'(DISP_DIGITS), 32'h0010);
      cyc(1, 0, 0, 0, 89 * TICK_DIV);
      chk("c0099", 32'(DISP_DIGITS), 32'h0099);
      cyc(1, 0, 0, 0, TICK_DIV);
      chk("c0100", 32'(DISP_DIGITS), 32'h0100);
      cyc(1, 0, 0, 0, 899 * TICK_DIV);
      chk("c0999", 32'(DISP_DIGITS), 32'h0999);
      cyc(1, 0, 0, 0, TICK_DIV);
      chk("c1000", 32'(DISP_DIGITS), 32'h1000);
      cyc(1, 0, 0, 0, 4999 * TICK_DIV);
      chk("c5999", 32'(DISP_DIGITS), 32'h5999);
      chk("c5999_ovf", 32'(OVF), 32'd0);
      cyc(1, 0, 0, 0, TICK_DIV);
      chk("wrap_disp", 32'(DISP_DIGITS), 32'h0000);
      chk("wrap_zero", 32'(ZERO), 32'd1);
      chk("wrap_ovf", 32'(OVF), 32'd1);
      cyc(1, 0, 0, 0, 1);
      chk("wrap_ovf_clr", 32'(OVF), 32'd0);
      cyc(1, 0, 0, 0, TICK_DIV - 1);
      chk("post_wrap", 32'(DISP_DIGITS), 32'h0001);

      // Lap freeze and same-cycle release.
      cyc(0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 5 * TICK_DIV);
      cyc(1, 0, 1, 0, 20 * TICK_DIV);
      chk("lap_frozen", 32'(DISP_DIGITS), 32'h0005);
      chk("lap_zero", 32'(ZERO), 32'd0);
      set_in(1, 0, 0, 0);
      #1;
      chk("lap_release", 32'(DISP_DIGITS), 32'h0025);
      step();

      // Clear and reset override RUN and LAP at 12.34.
      lap_clear_test(1'b0);
      lap_clear_test(1'b1);

      // Randomized control traffic.
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
         step();
      end

      sb_en = 1'b0;
      chk("sb_drain", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
